// File: rtl/arm_decode.sv
// arm_decode: single-cycle ARM decode/execute slice holding r0-r14, PC and CPSR.
// Decode, register reads, operand-2 muxing, barrel shifter and ALU are combinational.
// PC, CPSR and register-file writes take effect on the rising clock edge.
module arm_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        cond_pass,
    input  logic [31:0] inst,
    output logic [3:0]  read_rn,
    output logic [3:0]  read_rm,
    output logic [3:0]  read_rs,
    output logic [3:0]  write_rd,
    output logic        rd_we,
    output logic        pc_we,
    output logic        cpsr_we,
    output logic [31:0] rd_in,
    output logic [31:0] pc_in,
    output logic [31:0] cpsr_in,
    output logic [31:0] rn_out,
    output logic [31:0] rm_out,
    output logic [31:0] rs_out,
    output logic [31:0] pc_out,
    output logic [31:0] cpsr_out,
    output logic [1:0]  shiftee_sel,
    output logic [7:0]  immed_8_shiftee_in,
    output logic [31:0] immed_32_shiftee_in,
    output logic [1:0]  shifter_sel,
    output logic [3:0]  rotate_imm_shifter_in,
    output logic [4:0]  shift_imm_shifter_in,
    output logic [3:0]  barrel_sel,
    output logic [3:0]  alu_sel,
    output logic [31:0] alu_out
);

    // Slot 15 is never written; r15 reads are served from the PC instead.
    logic [31:0] r_regs [16];
    logic [31:0] r_pc;
    logic [31:0] r_cpsr;

    logic        w_is_branch;
    logic        w_is_ls;
    logic        w_is_dp;
    logic        w_imm_op;
    logic        w_op_test;
    logic        w_dp_pc;
    logic        w_c_in;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_plus8;
    logic [31:0] w_shiftee;
    logic [7:0]  w_shamt;
    logic [4:0]  w_amt5;
    logic [4:0]  w_idx_m1;
    logic [4:0]  w_idx_neg;
    logic [31:0] w_ror;
    logic [31:0] w_bs_out;
    logic        w_bs_co;
    logic [31:0] w_x;
    logic [31:0] w_y;
    logic        w_cin;
    logic        w_arith;
    logic [32:0] w_sum;
    logic        w_n;
    logic        w_z;
    logic        w_c;
    logic        w_v;
    logic        w_unused;

    // Condition field is resolved upstream and arrives as cond_pass.
    assign w_unused = ^inst[31:28];

    assign w_is_branch = (inst[27:25] == 3'b101);
    assign w_is_ls     = (inst[27:26] == 2'b01);
    assign w_is_dp     = !w_is_branch && !w_is_ls;
    // Load/store uses I=0 for its immediate offset form, the opposite of DP.
    assign w_imm_op    = w_is_ls ? !inst[25] : inst[25];
    assign w_op_test   = w_is_dp && (inst[24:23] == 2'b10);

    assign immed_8_shiftee_in    = inst[7:0];
    assign immed_32_shiftee_in   = {{8{inst[23]}}, inst[23:0]};
    assign rotate_imm_shifter_in = inst[11:8];
    assign shift_imm_shifter_in  = inst[11:7];

    assign pc_out     = r_pc;
    assign cpsr_out   = r_cpsr;
    assign w_c_in     = r_cpsr[29];
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_plus8 = r_pc + 32'd8;

    // Decode: register indices and operand-2 / ALU control selection
    always_comb begin
        read_rn     = inst[19:16];
        write_rd    = inst[15:12];
        read_rs     = inst[11:8];
        read_rm     = inst[3:0];
        shiftee_sel = 2'd0;
        shifter_sel = 2'd1;
        barrel_sel  = 4'd0;
        alu_sel     = inst[24:21];
        if (w_is_branch) begin
            read_rn     = 4'd15;
            write_rd    = 4'd14;
            shiftee_sel = 2'd2;
            shifter_sel = 2'd3;
            barrel_sel  = 4'd0;
            alu_sel     = 4'd4;
        end else begin
            if (w_imm_op) begin
                shiftee_sel = 2'd1;
                shifter_sel = 2'd0;
                barrel_sel  = 4'd8;
            end else if (inst[4]) begin
                shiftee_sel = 2'd0;
                shifter_sel = 2'd2;
                barrel_sel  = {2'b01, inst[6:5]};
            end else begin
                shiftee_sel = 2'd0;
                shifter_sel = 2'd1;
                barrel_sel  = {2'b00, inst[6:5]};
            end
            if (w_is_ls) begin
                alu_sel = inst[23] ? 4'd4 : 4'd2;
            end
        end
    end

    // Register reads; r15 reads as PC+8
    always_comb begin
        rn_out = (read_rn == 4'd15) ? w_pc_plus8 : r_regs[read_rn];
        rm_out = (read_rm == 4'd15) ? w_pc_plus8 : r_regs[read_rm];
        rs_out = (read_rs == 4'd15) ? w_pc_plus8 : r_regs[read_rs];
    end

    // Shiftee and shift-amount muxes
    always_comb begin
        unique case (shiftee_sel)
            2'd0:    w_shiftee = rm_out;
            2'd1:    w_shiftee = {24'd0, immed_8_shiftee_in};
            2'd2:    w_shiftee = immed_32_shiftee_in;
            default: w_shiftee = 32'd0;
        endcase
        unique case (shifter_sel)
            2'd0:    w_shamt = {3'd0, rotate_imm_shifter_in, 1'b0};
            2'd1:    w_shamt = {3'd0, shift_imm_shifter_in};
            2'd2:    w_shamt = rs_out[7:0];
            default: w_shamt = 8'd2;
        endcase
    end

    assign w_amt5    = w_shamt[4:0];
    assign w_idx_m1  = w_amt5 - 5'd1;
    assign w_idx_neg = 5'd0 - w_amt5;
    assign w_ror     = (w_shiftee >> w_amt5) | (w_shiftee << (6'd32 - {1'b0, w_amt5}));

    // Barrel shifter with ARM carry-out; amount 0 passes the operand and CPSR.C through
    always_comb begin
        w_bs_out = w_shiftee;
        w_bs_co  = w_c_in;
        case (barrel_sel)
            4'd0: if (w_amt5 != 5'd0) begin
                w_bs_out = w_shiftee << w_amt5;
                w_bs_co  = w_shiftee[w_idx_neg];
            end
            4'd1: if (w_amt5 == 5'd0) begin
                w_bs_out = 32'd0;
                w_bs_co  = w_shiftee[31];
            end else begin
                w_bs_out = w_shiftee >> w_amt5;
                w_bs_co  = w_shiftee[w_idx_m1];
            end
            4'd2: if (w_amt5 == 5'd0) begin
                w_bs_out = {32{w_shiftee[31]}};
                w_bs_co  = w_shiftee[31];
            end else begin
                w_bs_out = $signed(w_shiftee) >>> w_amt5;
                w_bs_co  = w_shiftee[w_idx_m1];
            end
            4'd3: if (w_amt5 == 5'd0) begin
                // RRX
                w_bs_out = {w_c_in, w_shiftee[31:1]};
                w_bs_co  = w_shiftee[0];
            end else begin
                w_bs_out = w_ror;
                w_bs_co  = w_shiftee[w_idx_m1];
            end
            4'd4: if (w_shamt != 8'd0) begin
                if (w_shamt < 8'd32) begin
                    w_bs_out = w_shiftee << w_amt5;
                    w_bs_co  = w_shiftee[w_idx_neg];
                end else begin
                    w_bs_out = 32'd0;
                    w_bs_co  = (w_shamt == 8'd32) ? w_shiftee[0] : 1'b0;
                end
            end
            4'd5: if (w_shamt != 8'd0) begin
                if (w_shamt < 8'd32) begin
                    w_bs_out = w_shiftee >> w_amt5;
                    w_bs_co  = w_shiftee[w_idx_m1];
                end else begin
                    w_bs_out = 32'd0;
                    w_bs_co  = (w_shamt == 8'd32) ? w_shiftee[31] : 1'b0;
                end
            end
            4'd6: if (w_shamt != 8'd0) begin
                if (w_shamt < 8'd32) begin
                    w_bs_out = $signed(w_shiftee) >>> w_amt5;
                    w_bs_co  = w_shiftee[w_idx_m1];
                end else begin
                    w_bs_out = {32{w_shiftee[31]}};
                    w_bs_co  = w_shiftee[31];
                end
            end
            4'd7: if (w_shamt != 8'd0) begin
                if (w_amt5 == 5'd0) begin
                    w_bs_co = w_shiftee[31];
                end else begin
                    w_bs_out = w_ror;
                    w_bs_co  = w_shiftee[w_idx_m1];
                end
            end
            4'd8: if (w_amt5 != 5'd0) begin
                w_bs_out = w_ror;
                w_bs_co  = w_shiftee[w_idx_m1];
            end
            default: ;
        endcase
    end

    // ALU: arithmetic ops share one adder as x + y + cin; SUB-type ops invert an operand
    always_comb begin
        w_x     = rn_out;
        w_y     = w_bs_out;
        w_cin   = 1'b0;
        w_arith = 1'b1;
        case (alu_sel)
            4'h2, 4'hA: begin w_y = ~w_bs_out; w_cin = 1'b1; end
            4'h3:       begin w_x = w_bs_out; w_y = ~rn_out; w_cin = 1'b1; end
            4'h4, 4'hB: w_cin = 1'b0;
            4'h5:       w_cin = w_c_in;
            4'h6:       begin w_y = ~w_bs_out; w_cin = w_c_in; end
            4'h7:       begin w_x = w_bs_out; w_y = ~rn_out; w_cin = w_c_in; end
            default:    w_arith = 1'b0;
        endcase
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {32'd0, w_cin};
        case (alu_sel)
            4'h0, 4'h8: alu_out = rn_out & w_bs_out;
            4'h1, 4'h9: alu_out = rn_out ^ w_bs_out;
            4'hC:       alu_out = rn_out | w_bs_out;
            4'hD:       alu_out = w_bs_out;
            4'hE:       alu_out = rn_out & ~w_bs_out;
            4'hF:       alu_out = ~w_bs_out;
            default:    alu_out = w_sum[31:0];
        endcase
        w_n = alu_out[31];
        w_z = (alu_out == 32'd0);
        w_c = w_arith ? w_sum[32] : w_bs_co;
        w_v = w_arith ? ((w_x[31] == w_y[31]) && (w_sum[31] != w_x[31])) : r_cpsr[28];
    end

    // Write-back controls and next-state data
    always_comb begin
        w_dp_pc = w_is_dp && !w_op_test && (write_rd == 4'd15);
        rd_we   = cond_pass && ((w_is_dp && !w_op_test && !w_dp_pc) ||
                                (w_is_branch && inst[24]));
        rd_in   = w_is_branch ? w_pc_plus4 : alu_out;
        pc_we   = 1'b1;
        pc_in   = (cond_pass && (w_is_branch || w_dp_pc)) ? alu_out : w_pc_plus4;
        cpsr_we = cond_pass && w_is_dp && (inst[20] || w_op_test);
        cpsr_in = {w_n, w_z, w_c, w_v, r_cpsr[27:0]};
    end

    // Architectural state update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 32'd0;
            end
            r_pc   <= 32'd0;
            r_cpsr <= 32'd0;
        end else begin
            if (rd_we) begin
                r_regs[write_rd] <= rd_in;
            end
            if (pc_we) begin
                r_pc <= pc_in;
            end
            if (cpsr_we) begin
                r_cpsr <= cpsr_in;
            end
        end
    end

endmodule

// File: tb/tb_arm_decode.sv
// Directed bench for arm_decode: hand-computed decode fields, datapath results and state.
module tb_arm_decode;

    logic        clk;
    logic        reset;
    logic        cond_pass;
    logic [31:0] inst;
    logic [3:0]  read_rn, read_rm, read_rs, write_rd;
    logic        rd_we, pc_we, cpsr_we;
    logic [31:0] rd_in, pc_in, cpsr_in;
    logic [31:0] rn_out, rm_out, rs_out, pc_out, cpsr_out;
    logic [1:0]  shiftee_sel, shifter_sel;
    logic [7:0]  immed_8_shiftee_in;
    logic [31:0] immed_32_shiftee_in;
    logic [3:0]  rotate_imm_shifter_in;
    logic [4:0]  shift_imm_shifter_in;
    logic [3:0]  barrel_sel, alu_sel;
    logic [31:0] alu_out;

    int n_total;
    int n_pass;

    arm_decode u_dut (
        .clk                   (clk),
        .reset                 (reset),
        .cond_pass             (cond_pass),
        .inst                  (inst),
        .read_rn               (read_rn),
        .read_rm               (read_rm),
        .read_rs               (read_rs),
        .write_rd              (write_rd),
        .rd_we                 (rd_we),
        .pc_we                 (pc_we),
        .cpsr_we               (cpsr_we),
        .rd_in                 (rd_in),
        .pc_in                 (pc_in),
        .cpsr_in               (cpsr_in),
        .rn_out                (rn_out),
        .rm_out                (rm_out),
        .rs_out                (rs_out),
        .pc_out                (pc_out),
        .cpsr_out              (cpsr_out),
        .shiftee_sel           (shiftee_sel),
        .immed_8_shiftee_in    (immed_8_shiftee_in),
        .immed_32_shiftee_in   (immed_32_shiftee_in),
        .shifter_sel           (shifter_sel),
        .rotate_imm_shifter_in (rotate_imm_shifter_in),
        .shift_imm_shifter_in  (shift_imm_shifter_in),
        .barrel_sel            (barrel_sel),
        .alu_sel               (alu_sel),
        .alu_out               (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Let the current instruction execute, then return on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        reset     = 1'b1;
        cond_pass = 1'b1;
        inst      = 32'h0;
        #3;
        check_val("rst_pc", pc_out, 32'h0);
        check_val("rst_cpsr", cpsr_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // pc=0: AND R1,R1,#2 with R1=0
        inst = 32'hE2011002; #1;
        check_val("and_rn", {28'd0, read_rn}, 32'd1);
        check_val("and_rd", {28'd0, write_rd}, 32'd1);
        check_val("and_shiftee", {30'd0, shiftee_sel}, 32'd1);
        check_val("and_shifter", {30'd0, shifter_sel}, 32'd0);
        check_val("and_barrel", {28'd0, barrel_sel}, 32'd8);
        check_val("and_alu", {28'd0, alu_sel}, 32'd0);
        check_val("and_imm8", {24'd0, immed_8_shiftee_in}, 32'h02);
        check_val("and_rd_in", rd_in, 32'h0);
        check_val("and_rd_we", {31'd0, rd_we}, 32'd1);
        check_val("and_pc_in", pc_in, 32'h4);
        next_cycle();

        // pc=4: CMP R7,R8 with both zero -> Z=1, C=1
        inst = 32'hE1570008; #1;
        check_val("cmp_alu", {28'd0, alu_sel}, 32'hA);
        check_val("cmp_rd_we", {31'd0, rd_we}, 32'd0);
        check_val("cmp_cpsr_we", {31'd0, cpsr_we}, 32'd1);
        check_val("cmp_cpsr_in", cpsr_in, 32'h6000_0000);
        next_cycle();
        check_val("cmp_cpsr", cpsr_out, 32'h6000_0000);

        // MVN R8,#0 -> R8=FFFFFFFF
        inst = 32'hE3E08000; #1;
        check_val("mvn_out", alu_out, 32'hFFFF_FFFF);
        next_cycle();

        // BIC R9,R8,#0xFF00
        inst = 32'hE3C89CFF; #1;
        check_val("bic_rot", {28'd0, rotate_imm_shifter_in}, 32'hC);
        check_val("bic_alu", {28'd0, alu_sel}, 32'hE);
        check_val("bic_rd", {28'd0, write_rd}, 32'd9);
        check_val("bic_rn", {28'd0, read_rn}, 32'd8);
        check_val("bic_out", alu_out, 32'hFFFF_00FF);
        next_cycle();

        // MOV R3,#4 ; MOV R2,#5
        inst = 32'hE3A03004; next_cycle();
        inst = 32'hE3A02005; next_cycle();

        // ADD R4,R3,R2 -> 9
        inst = 32'hE0834002; #1;
        check_val("add_shiftee", {30'd0, shiftee_sel}, 32'd0);
        check_val("add_alu", {28'd0, alu_sel}, 32'd4);
        check_val("add_rm", {28'd0, read_rm}, 32'd2);
        check_val("add_out", alu_out, 32'd9);
        next_cycle();

        // MOV R12,R4,ROR R3 -> 9 ror 4
        inst = 32'hE1A0C374; #1;
        check_val("ror_rs", {28'd0, read_rs}, 32'd3);
        check_val("ror_rm", {28'd0, read_rm}, 32'd4);
        check_val("ror_shifter", {30'd0, shifter_sel}, 32'd2);
        check_val("ror_barrel", {28'd0, barrel_sel}, 32'd7);
        check_val("ror_alu", {28'd0, alu_sel}, 32'hD);
        check_val("ror_rd", {28'd0, write_rd}, 32'hC);
        check_val("ror_out", alu_out, 32'h9000_0000);
        next_cycle();

        // MOVS R5,R12,ASR #32 (encoded amount 0)
        inst = 32'hE1B0504C; #1;
        check_val("asr32_out", alu_out, 32'hFFFF_FFFF);
        check_val("asr32_cpsr_in", cpsr_in, 32'hA000_0000);
        next_cycle();

        // MOVS R6,R12,RRX with C=1
        inst = 32'hE1B0606C; #1;
        check_val("rrx_out", alu_out, 32'hC800_0000);
        check_val("rrx_cpsr_in", cpsr_in, 32'h8000_0000);
        next_cycle();

        // MVN R10,#0x80000000 ; ADDS R11,R10,#1 -> signed overflow
        inst = 32'hE3E0A102; #1;
        check_val("mvn2_out", alu_out, 32'h7FFF_FFFF);
        next_cycle();
        inst = 32'hE29AB001; #1;
        check_val("adds_out", alu_out, 32'h8000_0000);
        check_val("adds_cpsr_in", cpsr_in, 32'h9000_0000);
        next_cycle();

        // Failed condition: no flag write, PC still advances
        cond_pass = 1'b0;
        inst = 32'hE1570008; #1;
        check_val("nc_cpsr_we", {31'd0, cpsr_we}, 32'd0);
        check_val("nc_pc_in", pc_in, 32'h34);
        next_cycle();
        check_val("nc_cpsr", cpsr_out, 32'h9000_0000);
        check_val("nc_pc", pc_out, 32'h34);

        // Asynchronous reset mid-sequence
        #2 reset = 1'b1;
        #1;
        check_val("areset_pc", pc_out, 32'h0);
        check_val("areset_cpsr", cpsr_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // BL with cond_pass=0: PC+4, R14 untouched
        inst = 32'hEB00000A; #1;
        check_val("blnc_rd_we", {31'd0, rd_we}, 32'd0);
        check_val("blnc_pc_in", pc_in, 32'h4);
        next_cycle();
        cond_pass = 1'b1;
        inst = 32'hE1A0000E; #1;
        check_val("blnc_pc", pc_out, 32'h4);
        check_val("blnc_r14", rm_out, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // BL taken from pc=0
        inst = 32'hEB00000A; #1;
        check_val("bl_rd", {28'd0, write_rd}, 32'hE);
        check_val("bl_rn", {28'd0, read_rn}, 32'hF);
        check_val("bl_rn_out", rn_out, 32'h8);
        check_val("bl_imm32", immed_32_shiftee_in, 32'hA);
        check_val("bl_shiftee", {30'd0, shiftee_sel}, 32'd2);
        check_val("bl_shifter", {30'd0, shifter_sel}, 32'd3);
        check_val("bl_alu", {28'd0, alu_sel}, 32'd4);
        check_val("bl_rd_in", rd_in, 32'h4);
        check_val("bl_rd_we", {31'd0, rd_we}, 32'd1);
        check_val("bl_pc_in", pc_in, 32'h30);
        next_cycle();
        inst = 32'hE1A0000E; #1;
        check_val("bl_pc", pc_out, 32'h30);
        check_val("bl_r14", rm_out, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arm_decode.md
# arm_decode

Single-cycle ARM instruction decode and execute slice: decodes a 32-bit ARM instruction into register-file, operand-2 mux, barrel-shifter and ALU controls. Contains the architectural state: r0–r14, PC and CPSR. Sits between instruction fetch, which supplies `inst`, and the condition checker, which supplies `cond_pass`. It exposes every internal control and datapath value for observation by the core and the bench.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `cond_pass` in 1: condition field satisfied for `inst`.
- `inst` in 32: current instruction.
- `read_rn`, `read_rm`, `read_rs`, `write_rd` out 4: register indices.
- `rd_we`, `pc_we`, `cpsr_we` out 1: write enables.
- `rd_in`, `pc_in`, `cpsr_in` out 32: next-state write data.
- `rn_out`, `rm_out`, `rs_out`, `pc_out`, `cpsr_out` out 32: register read data and current PC/CPSR.
- `shiftee_sel` out 2, `immed_8_shiftee_in` out 8, `immed_32_shiftee_in` out 32: shiftee mux controls and data.
- `shifter_sel` out 2, `rotate_imm_shifter_in` out 4, `shift_imm_shifter_in` out 5: shift-amount mux controls and data.
- `barrel_sel` out 4: barrel shifter operation.
- `alu_sel` out 4, `alu_out` out 32: ALU opcode and result.

## Operation
- Field extraction:
  - `read_rn`=inst[19:16], `write_rd`=inst[15:12], `read_rs`=inst[11:8], `read_rm`=inst[3:0].
  - `immed_8`=inst[7:0], `rotate_imm`=inst[11:8], `shift_imm`=inst[11:7].
  - `immed_32`=sign-extended inst[23:0].
- Instruction classes:
  - Data processing (DP): inst[27:26]=00.
  - Load/store (LS): 01. LS is decoded only, with no register, PC or CPSR writes.
  - Branch (B/BL): inst[27:25]=101.
- Register reads: reading index 15 returns `pc_out`+8.
- Shiftee mux, by `shiftee_sel`:
  - 0 selects `rm_out`.
  - 1 selects zero-extended `immed_8` (DP with I=1, i.e. inst[25]=1).
  - 2 selects `immed_32` (branch).
  - 3 selects 0.
- Shift-amount mux, by `shifter_sel`:
  - 0 selects 2×`rotate_imm`.
  - 1 selects `shift_imm`.
  - 2 selects `rs_out`[7:0].
  - 3 selects constant 2.
- Control settings per class:
  - Immediate DP: `shiftee_sel`=1, `shifter_sel`=0, `barrel_sel`=8 (ROR).
  - Register-shift DP (I=0, inst[4]=1): `shiftee_sel`=0, `shifter_sel`=2, `barrel_sel`={0,1,inst[6:5]}.
  - Immediate-shift DP (I=0, inst[4]=0): `shiftee_sel`=0, `shifter_sel`=1, `barrel_sel`={0,0,inst[6:5]}.
  - Branch: `shiftee_sel`=2, `shifter_sel`=3, `barrel_sel`=0 (LSL), `read_rn`=15, `alu_sel`=4 (ADD), `write_rd`=14.
  - LS: `alu_sel`=4 when U (inst[23]) is 1, else 2 (SUB). Operand-2 controls are as for DP with the I sense inverted.
- Barrel shifter:
  - Codes 0–3 and 4–7 are LSL/LSR/ASR/ROR.
  - Immediate LSR/ASR with amount 0 means 32.
  - Immediate ROR with amount 0 means RRX.
  - Register amounts ≥32 follow ARM rules.
  - Code 8 is a plain 32-bit rotate right.
  - Shifter carry-out follows ARM rules; it is CPSR.C when the shift amount is 0.
- ALU: `alu_sel`=inst[24:21] for DP, with the 16 standard ARM opcodes AND…MVN. ADC/SBC/RSC use CPSR.C.
- Writes (all gated by `cond_pass`):
  - `rd_we`=1 for DP excluding TST/TEQ/CMP/CMN (opcode 10xx), and for BL (inst[24]=1).
  - `rd_in`=`alu_out` for DP; `rd_in`=`pc_out`+4 for BL.
  - A DP write to Rd=15 goes to the PC instead of the register file.
  - `pc_we`=1 always.
  - `pc_in`=`alu_out` for a taken branch or a DP write to r15; otherwise `pc_out`+4.
  - `cpsr_we`=1 for DP with S=1 (inst[20]) or opcode 10xx.
  - `cpsr_in`={N,Z,C,V,`cpsr_out`[27:0]}.
  - C comes from the ALU carry for arithmetic ops and from the shifter carry for logical ops.
  - V is updated only by arithmetic ops.
- When `cond_pass`=0: no register or CPSR write; the PC still advances by 4.
- Decode of an undefined pattern: treat as DP.

## Timing
- Decode, reads, shifter and ALU are combinational from `inst`, `cond_pass` and the current state.
- State updates on the rising `clk`.
- Asynchronous `reset`: r0–r14, PC and CPSR clear to 0, so `pc_out`=0 and `cpsr_out`=0.
- A write to register r and a read of r in the same cycle return the old value.

## Test plan
- E2011002 (AND R1,R1,#2) → `read_rn`=1, `write_rd`=1, `shiftee_sel`=1, `shifter_sel`=0, `barrel_sel`=8, `alu_sel`=0, `immed_8`=02. With R1=0: `rd_in`=0, `rd_we`=1.
- E3C89CFF (BIC R9,R8,#0xFF00) → `rotate_imm`=C, operand 0x0000FF00, `alu_sel`=E, `write_rd`=9, `read_rn`=8.
- E0834002 (ADD R4,R3,R2), then E1570008 (CMP R7,R8):
  - ADD → `shiftee_sel`=0, `alu_sel`=4, `read_rm`=2.
  - CMP → `alu_sel`=A, `rd_we`=0, `cpsr_we`=1. With R7=R8=0: Z=1, C=1.
- E1A0C374 (MOV R12,R4,ROR R3) → `read_rs`=3, `read_rm`=4, `shifter_sel`=2, `barrel_sel`=7, `alu_sel`=D, `write_rd`=C.
- After reset, EB00000A (BL) → `write_rd`=E, `rd_in`=4, `pc_in`=0x30. After one clock: `pc_out`=0x30, R14=4. With `cond_pass`=0 instead: `pc_out`=4, R14 unchanged.
- Assert `reset` mid-sequence → PC and CPSR read 0 immediately, without waiting for a clock edge.
